data_memory: RTL and testbench

Multi-cycle data memory that answers the CPU's MEM stage memory port. It accepts a load or store request from the EX/MEM pipeline register and holds BUSYWAIT high while the access is in progress, which stalls every pipeline register. It then completes the access with RISC-V byte, halfword or word semantics selected by FUNC3. It sits outside the CPU top and drives the CPU's READ_DATA and BUSYWAIT inputs.

---
 rtl/data_memory.sv | 174 +++++++++++++++++
 tb/tb_data_memory.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Multi-cycle data memory for the MEM stage: RV32 byte/half/word loads and stores.
// Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module data_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  input  logic [2:0]  FUNC3,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int AW = ADDR_WIDTH + 2;

  logic [31:0]   mem [2**ADDR_WIDTH];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [2:0]    f3_q, f3_d;
  logic          wr_q, wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q;

  logic          req, idle, exec_en;
  logic [AW-1:0] x_addr;
  logic [31:0]   x_wd;
  logic [2:0]    x_f3;
  logic          x_wr;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]    lane;
  logic          is_b, is_h, is_w, sx, mis, we;
  logic [31:0]   word, st_data, ld_data;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;
  logic          unused_addr;

  assign unused_addr = ^MEM_ADDRESS[31:AW];

  assign req  = MEM_READ | MEM_WRITE;
  assign idle = (state_q == IDLE);

  // LATENCY=1 executes on the accepting edge, straight from the inputs.
  assign exec_en = RESET &
    ((idle & req & (LATENCY == 1)) |
     ((state_q == BUSY) & (cnt_q == 4'd1)));

  assign x_addr = idle ? MEM_ADDRESS[AW-1:0] : addr_q;
  assign x_wd   = idle ? MEM_WRITE_DATA : wd_q;
  assign x_f3   = idle ? FUNC3 : f3_q;
  assign x_wr   = idle ? MEM_WRITE : wr_q;

  assign idx  = x_addr[AW-1:2];
  assign lane = x_addr[1:0];
  assign is_b = (x_f3[1:0] == 2'b00);
  assign is_h = (x_f3[1:0] == 2'b01);
  assign is_w = ~is_b & ~is_h;
  assign sx   = ~x_f3[2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (is_h & lane[0]) | (is_w & (lane != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign word   = mem[idx];
  assign byte_v = word[{lane, 3'b000} +: 8];
  assign half_v = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_data = word;
    unique case (1'b1)
      is_b:    ld_data = {{24{sx & byte_v[7]}}, byte_v};
      is_h:    ld_data = {{16{sx & half_v[15]}}, half_v};
      default: ld_data = word;
    endcase
  end

  assign rdata_d = mis ? 32'd0 : ld_data;

  always_comb begin
    be      = 4'b1111;
    st_data = x_wd;
    unique case (1'b1)
      is_b: begin
        be      = 4'b0001 << lane;
        st_data = {4{x_wd[7:0]}};
      end
      is_h: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{x_wd[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = x_wd;
      end
    endcase
  end

  assign we = exec_en & x_wr & ~mis;

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = MEM_ADDRESS[AW-1:0];
          wd_d    = MEM_WRITE_DATA;
          f3_d    = FUNC3;
          wr_d    = MEM_WRITE;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wd_q    <= 32'd0;
      f3_q    <= 3'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      if (exec_en & ~x_wr) rdata_q <= rdata_d;
      err_q   <= exec_en & mis;
    end
  end

  assign BUSYWAIT  = RESET & ((idle & req) | (state_q == BUSY));
  assign READ_DATA = rdata_q;
  assign ERROR     = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (LATENCY=4).
// Honours DMEM_ALIGN_CHECK_EN for the misaligned-load expectations.
module tb_data_memory;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ, MEM_WRITE;
  logic [31:0] MEM_ADDRESS, MEM_WRITE_DATA;
  logic [2:0]  FUNC3;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT, ERROR;

  int checks = 0;
  int failures = 0;
  int cyc;

  data_memory #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .FUNC3(FUNC3), .READ_DATA(READ_DATA),
    .BUSYWAIT(BUSYWAIT), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts BUSYWAIT-high cycles from the request until the DONE cycle.
  task automatic wait_busy(input int start, output int n);
    n = start;
    while (BUSYWAIT === 1'b1 && n < 40) begin
      n++;
      @(negedge CLK); #1;
    end
  endtask

  // Issue a request at a negedge, return in the DONE cycle with inputs dropped.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3,
                        output int n);
    @(negedge CLK);
    MEM_READ = rd; MEM_WRITE = wr;
    MEM_ADDRESS = a; MEM_WRITE_DATA = d; FUNC3 = f3;
    #1;
    wait_busy(0, n);
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    MEM_ADDRESS = 32'd0; MEM_WRITE_DATA = 32'd0; FUNC3 = 3'b010;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_rdata", READ_DATA, 32'd0);
    chk("rst_err", {31'd0, ERROR}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, cyc);
    chk("sw_cycles", cyc, 4);
    chk("sw_rdata_kept", READ_DATA, 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, cyc);
    chk("lw_cycles", cyc, 4);
    chk("lw_done_busy", {31'd0, BUSYWAIT}, 32'd0);
    chk("lw_data", READ_DATA, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000, cyc);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, cyc);
    chk("sb_word", READ_DATA, 32'h80ADBEEF);
    access(1'b1, 1'b0, 32'h13, 32'd0, 3'b000, cyc);
    chk("lb_13", READ_DATA, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h13, 32'd0, 3'b100, cyc);
    chk("lbu_13", READ_DATA, 32'h00000080);
    access(1'b1, 1'b0, 32'h11, 32'd0, 3'b000, cyc);
    chk("lb_11", READ_DATA, 32'hFFFFFFBE);

    access(1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010, cyc);
    access(1'b0, 1'b1, 32'h22, 32'hFFFF8001, 3'b001, cyc);
    access(1'b1, 1'b0, 32'h22, 32'd0, 3'b001, cyc);
    chk("lh_22", READ_DATA, 32'hFFFF8001);
    access(1'b1, 1'b0, 32'h22, 32'd0, 3'b101, cyc);
    chk("lhu_22", READ_DATA, 32'h00008001);
    access(1'b1, 1'b0, 32'h20, 32'd0, 3'b101, cyc);
    chk("lhu_20_kept", READ_DATA, 32'h00003344);
    access(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, cyc);
    chk("sh_word", READ_DATA, 32'h80013344);

    access(1'b1, 1'b0, 32'h10, 32'd0, 3'b011, cyc);
    chk("f3_011_as_w", READ_DATA, 32'h80ADBEEF);
    access(1'b1, 1'b0, 32'h1010, 32'd0, 3'b010, cyc);
    chk("addr_wrap", READ_DATA, 32'h80ADBEEF);

    access(1'b1, 1'b1, 32'h30, 32'h00000055, 3'b010, cyc);
    chk("rdwr_no_load", READ_DATA, 32'h80ADBEEF);
    access(1'b1, 1'b0, 32'h30, 32'd0, 3'b010, cyc);
    chk("rdwr_stored", READ_DATA, 32'h00000055);

    // Address changes mid-BUSY; request held through DONE into next IDLE.
    @(negedge CLK);
    MEM_READ = 1'b1; MEM_ADDRESS = 32'h10; FUNC3 = 3'b010;
    #1;
    @(negedge CLK);
    MEM_ADDRESS = 32'h20;
    #1;
    wait_busy(1, cyc);
    chk("latched_cycles", cyc, 4);
    chk("latched_addr", READ_DATA, 32'h80ADBEEF);
    @(negedge CLK); #1;
    chk("held_reaccept", {31'd0, BUSYWAIT}, 32'd1);
    wait_busy(0, cyc);
    MEM_READ = 1'b0;
    chk("held_cycles", cyc, 4);
    chk("held_new_addr", READ_DATA, 32'h80013344);

    access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 3'b010, cyc);
    access(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, cyc);

    // Reset in the second BUSY cycle of a store.
    @(negedge CLK);
    MEM_WRITE = 1'b1; MEM_ADDRESS = 32'h40;
    MEM_WRITE_DATA = 32'h12345678; FUNC3 = 3'b010;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("abort_busy", {31'd0, BUSYWAIT}, 32'd0);
    chk("abort_rdata", READ_DATA, 32'd0);
    @(negedge CLK);
    MEM_WRITE = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    access(1'b1, 1'b0, 32'h40, 32'd0, 3'b010, cyc);
    chk("abort_no_write", READ_DATA, 32'hCAFEF00D);

    access(1'b1, 1'b0, 32'h41, 32'd0, 3'b010, cyc);
    chk("mis_cycles", cyc, 4);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_err", {31'd0, ERROR}, 32'd1);
    chk("mis_rdata", READ_DATA, 32'd0);
    @(negedge CLK); #1;
    chk("mis_err_clr", {31'd0, ERROR}, 32'd0);
`else
    chk("mis_err", {31'd0, ERROR}, 32'd0);
    chk("mis_rdata", READ_DATA, 32'hCAFEF00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
